// File: rtl/branch_resolution_unit_pkg.sv
// Shared opcode header and branch-resolution state encoding.
package branch_resolution_unit_pkg;

    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;

    localparam logic BRU_RUN     = 1'b0;
    localparam logic BRU_RECOVER = 1'b1;

    typedef enum logic {
        StRun     = BRU_RUN,
        StRecover = BRU_RECOVER
    } bru_state_e;

    function automatic logic is_branch(input logic [6:0] opcode);
        return opcode == OPCODE_BRANCH;
    endfunction

endpackage

// File: rtl/branch_resolution_unit_if.sv
// Prediction-in / resolution-out bundle between the pipeline and the branch resolution unit.
interface branch_resolution_unit_if #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) ();

    logic [6:0]      IF_opcode;
    logic [XLEN-1:0] IF_pc;
    logic [XLEN-1:0] IF_imm;
    logic            IF_pred_taken;
    logic [XLEN-1:0] IF_pred_target;
    logic            stall_IF_ID;
    logic            stall_ID_EX;
    logic            EX_actual_taken;
    logic            flush;
    logic [XLEN-1:0] redirect_pc;
    logic            EX_branch;
    logic            EX_branch_taken;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] mispredict_count;

    modport master (
        output IF_opcode, IF_pc, IF_imm, IF_pred_taken, IF_pred_target,
        output stall_IF_ID, stall_ID_EX, EX_actual_taken,
        input  flush, redirect_pc, EX_branch, EX_branch_taken, branch_count, mispredict_count
    );

    modport slave (
        input  IF_opcode, IF_pc, IF_imm, IF_pred_taken, IF_pred_target,
        input  stall_IF_ID, stall_ID_EX, EX_actual_taken,
        output flush, redirect_pc, EX_branch, EX_branch_taken, branch_count, mispredict_count
    );

endinterface

// File: rtl/branch_resolution_unit_bru_track_stage.sv
// One pipeline tracking register for a branch prediction; flush beats load, load beats hold.
module bru_track_stage #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            i_load,
    input  logic            i_flush,
    input  logic            i_valid,
    input  logic            i_pred_taken,
    input  logic [XLEN-1:0] i_pred_target,
    input  logic [XLEN-1:0] i_pc,
    input  logic [XLEN-1:0] i_imm,
    output logic            o_valid,
    output logic            o_pred_taken,
    output logic [XLEN-1:0] o_pred_target,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_imm
);

    logic            r_valid;
    logic            r_pred_taken;
    logic [XLEN-1:0] r_pred_target;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_imm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid       <= 1'b0;
            r_pred_taken  <= 1'b0;
            r_pred_target <= '0;
            r_pc          <= '0;
            r_imm         <= '0;
        end else if (i_flush) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid       <= i_valid;
            r_pred_taken  <= i_pred_taken;
            r_pred_target <= i_pred_target;
            r_pc          <= i_pc;
            r_imm         <= i_imm;
        end
    end

    assign o_valid       = r_valid;
    assign o_pred_taken  = r_pred_taken;
    assign o_pred_target = r_pred_target;
    assign o_pc          = r_pc;
    assign o_imm         = r_imm;

endmodule

// File: rtl/branch_resolution_unit.sv
// EX-side branch resolution: tracks predictions through IF/ID and ID/EX, flags mispredicts,
// produces the corrected fetch PC and keeps saturating statistics.
module branch_resolution_unit
    import branch_resolution_unit_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = 32
) (
    input logic                     clk,
    input logic                     reset,
    branch_resolution_unit_if.slave bru
);

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};
    localparam logic [XLEN-1:0]  InstBytes = XLEN'(4);

    bru_state_e r_state, w_state_next;

    logic            w_ifid_valid, w_ifid_pred_taken;
    logic [XLEN-1:0] w_ifid_pred_target, w_ifid_pc, w_ifid_imm;
    logic            w_idex_valid, w_idex_pred_taken;
    logic [XLEN-1:0] w_idex_pred_target, w_idex_pc, w_idex_imm;

    logic            w_res_en;
    logic            w_mispredict;
    logic [XLEN-1:0] w_actual_target;
    logic [XLEN-1:0] w_fallthrough;
    logic [XLEN-1:0] w_redirect_pc;
    logic            w_branch_taken;

    logic [CNT_W-1:0] r_branch_count;
    logic [CNT_W-1:0] r_mispredict_count;

    bru_track_stage #(.XLEN(XLEN)) u_ifid (
        .clk           (clk),
        .reset         (reset),
        .i_load        (~bru.stall_IF_ID),
        .i_flush       (w_mispredict),
        .i_valid       (is_branch(bru.IF_opcode)),
        .i_pred_taken  (bru.IF_pred_taken),
        .i_pred_target (bru.IF_pred_target),
        .i_pc          (bru.IF_pc),
        .i_imm         (bru.IF_imm),
        .o_valid       (w_ifid_valid),
        .o_pred_taken  (w_ifid_pred_taken),
        .o_pred_target (w_ifid_pred_target),
        .o_pc          (w_ifid_pc),
        .o_imm         (w_ifid_imm)
    );

    // A stalled IF/ID feeding an advancing ID/EX must not duplicate its branch: insert a bubble.
    bru_track_stage #(.XLEN(XLEN)) u_idex (
        .clk           (clk),
        .reset         (reset),
        .i_load        (~bru.stall_ID_EX),
        .i_flush       (w_mispredict),
        .i_valid       (w_ifid_valid & ~bru.stall_IF_ID),
        .i_pred_taken  (w_ifid_pred_taken),
        .i_pred_target (w_ifid_pred_target),
        .i_pc          (w_ifid_pc),
        .i_imm         (w_ifid_imm),
        .o_valid       (w_idex_valid),
        .o_pred_taken  (w_idex_pred_taken),
        .o_pred_target (w_idex_pred_target),
        .o_pc          (w_idex_pc),
        .o_imm         (w_idex_imm)
    );

    assign w_actual_target = w_idex_pc + w_idex_imm;
    assign w_fallthrough   = w_idex_pc + InstBytes;

    always_comb begin
        w_state_next   = r_state;
        w_res_en       = 1'b0;
        w_mispredict   = 1'b0;
        w_branch_taken = 1'b0;
        w_redirect_pc  = '0;
        unique case (r_state)
            StRun: begin
                w_res_en = w_idex_valid & ~bru.stall_ID_EX;
                if (w_res_en) begin
                    w_branch_taken = bru.EX_actual_taken;
                    w_mispredict   = (w_idex_pred_taken != bru.EX_actual_taken) ||
                                     (w_idex_pred_taken && bru.EX_actual_taken &&
                                      (w_idex_pred_target != w_actual_target));
                end
                if (w_mispredict) begin
                    w_redirect_pc = bru.EX_actual_taken ? w_actual_target : w_fallthrough;
                    w_state_next  = StRecover;
                end
            end
            StRecover: w_state_next = StRun;
            default:   w_state_next = StRun;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state            <= StRun;
            r_branch_count     <= '0;
            r_mispredict_count <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_res_en && (r_branch_count != CntMax)) begin
                r_branch_count <= r_branch_count + CntOne;
            end
            if (w_mispredict && (r_mispredict_count != CntMax)) begin
                r_mispredict_count <= r_mispredict_count + CntOne;
            end
        end
    end

    assign bru.flush            = w_mispredict;
    assign bru.redirect_pc      = w_redirect_pc;
    assign bru.EX_branch        = w_res_en;
    assign bru.EX_branch_taken  = w_branch_taken;
    assign bru.branch_count     = r_branch_count;
    assign bru.mispredict_count = r_mispredict_count;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with a queue of expected resolutions.
module tb_branch_resolution_unit;

    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpNop    = 7'b0010011;

    typedef struct {
        logic        taken;
        logic        fl;
        logic [31:0] rpc;
    } exp_t;

    logic clk;
    logic reset;
    int   n_vec;
    int   n_err;
    exp_t sb[$];

    branch_resolution_unit_if #(.XLEN(32), .CNT_W(4)) bus ();

    branch_resolution_unit #(.XLEN(32), .CNT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bru   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_if(input logic [6:0] op, input logic [31:0] pc, input logic [31:0] imm,
                          input logic pt, input logic [31:0] ptgt);
        bus.IF_opcode      = op;
        bus.IF_pc          = pc;
        bus.IF_imm         = imm;
        bus.IF_pred_taken  = pt;
        bus.IF_pred_target = ptgt;
    endtask

    // Fetch one branch followed by a nop; leaves the branch sitting in ID/EX.
    task automatic issue(input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                         input logic [31:0] ptgt, input logic at, input logic fl,
                         input logic [31:0] rpc);
        exp_t e;
        e.taken = at;
        e.fl    = fl;
        e.rpc   = rpc;
        sb.push_back(e);
        bus.stall_IF_ID = 1'b0;
        bus.stall_ID_EX = 1'b0;
        set_if(OpBranch, pc, imm, pt, ptgt);
        tick();
        set_if(OpNop, 32'h0, 32'h0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic resolve(input logic at);
        exp_t e;
        bus.EX_actual_taken = at;
        #2;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            chk("ex_branch", 32'(bus.EX_branch), 32'd1);
            chk("ex_branch_taken", 32'(bus.EX_branch_taken), 32'(e.taken));
            chk("flush", 32'(bus.flush), 32'(e.fl));
            chk("redirect_pc", bus.redirect_pc, e.rpc);
        end
        tick();
        bus.EX_actual_taken = 1'b0;
    endtask

    task automatic idle_chk(input string tag);
        #2;
        chk({tag, "_ex_branch"}, 32'(bus.EX_branch), 32'd0);
        chk({tag, "_flush"}, 32'(bus.flush), 32'd0);
        tick();
    endtask

    task automatic cnt_chk(input string tag, input int br, input int mis);
        chk({tag, "_branch_count"}, 32'(bus.branch_count), 32'(br));
        chk({tag, "_mispredict_count"}, 32'(bus.mispredict_count), 32'(mis));
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b1;
        bus.stall_IF_ID     = 1'b0;
        bus.stall_ID_EX     = 1'b0;
        bus.EX_actual_taken = 1'b0;
        set_if(OpNop, 32'h0, 32'h0, 1'b0, 32'h0);
        #2;
        chk("rst_flush", 32'(bus.flush), 32'd0);
        chk("rst_redirect", bus.redirect_pc, 32'd0);
        chk("rst_ex_branch", 32'(bus.EX_branch), 32'd0);
        chk("rst_ex_taken", 32'(bus.EX_branch_taken), 32'd0);
        cnt_chk("rst", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Correct not-taken, then the three mispredict flavours, then a correct taken.
        issue(32'h100, 32'h40, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        resolve(1'b0);
        cnt_chk("nt_nt", 1, 0);

        issue(32'h100, 32'h40, 1'b0, 32'h0, 1'b1, 1'b1, 32'h140);
        resolve(1'b1);
        idle_chk("recover1");
        cnt_chk("nt_t", 2, 1);

        issue(32'h100, 32'h40, 1'b1, 32'h140, 1'b0, 1'b1, 32'h104);
        resolve(1'b0);
        idle_chk("recover2");

        issue(32'h100, 32'h40, 1'b1, 32'h180, 1'b1, 1'b1, 32'h140);
        resolve(1'b1);
        idle_chk("recover3");

        issue(32'h100, 32'h40, 1'b1, 32'h140, 1'b1, 1'b0, 32'h0);
        resolve(1'b1);
        cnt_chk("t_t", 5, 3);

        // Branch held in EX for three cycles resolves only on release.
        issue(32'h200, 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        bus.stall_IF_ID = 1'b1;
        bus.stall_ID_EX = 1'b1;
        for (int i = 0; i < 3; i++) idle_chk("stalled");
        bus.stall_IF_ID = 1'b0;
        bus.stall_ID_EX = 1'b0;
        resolve(1'b0);
        idle_chk("post_stall");
        cnt_chk("stall", 6, 3);

        // Back-to-back: older mispredicts, younger must be squashed.
        sb.push_back('{taken: 1'b1, fl: 1'b1, rpc: 32'h320});
        set_if(OpBranch, 32'h300, 32'h20, 1'b0, 32'h0);
        tick();
        set_if(OpBranch, 32'h304, 32'h8, 1'b0, 32'h0);
        tick();
        set_if(OpNop, 32'h0, 32'h0, 1'b0, 32'h0);
        resolve(1'b1);
        for (int i = 0; i < 3; i++) idle_chk("squash");
        cnt_chk("squash", 7, 4);

        // Reset asserted while in RECOVER.
        issue(32'h400, 32'h8, 1'b0, 32'h0, 1'b1, 1'b1, 32'h408);
        resolve(1'b1);
        cnt_chk("pre_reset", 8, 5);
        #1;
        reset = 1'b1;
        #1;
        chk("mid_rst_state", 32'(dut.r_state), 32'd0);
        chk("mid_rst_flush", 32'(bus.flush), 32'd0);
        chk("mid_rst_redirect", bus.redirect_pc, 32'd0);
        chk("mid_rst_ex_branch", 32'(bus.EX_branch), 32'd0);
        cnt_chk("mid_rst", 0, 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        cnt_chk("post_rst", 0, 0);

        // 20 correct branches on a 4-bit counter must stick at 15.
        for (int i = 0; i < 20; i++) begin
            issue(32'h500 + 32'(i * 4), 32'h10, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
            resolve(1'b0);
        end
        cnt_chk("saturate", 15, 0);
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/branch_resolution_unit.md
Name: branch_resolution_unit

Overview:
- EX-side counterpart of the IF branch predictor.
- Carries each fetched branch's prediction (taken flag, target, pc, imm) through IF/ID and ID/EX tracking registers, honouring pipeline stalls and flushes.
- When the branch reaches EX, compares the prediction with the actual outcome from the branch comparator. On a mismatch it raises flush and a corrected PC.
- Drives the resolution pair back to the predictor and keeps saturating branch/mispredict statistics.

Parameters:
XLEN, 32, datapath/address width
CNT_W, 32, width of statistics counters

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
IF_opcode  input  7  opcode of instruction in IF
IF_pc  input  XLEN  PC of instruction in IF
IF_imm  input  XLEN  B-type immediate of instruction in IF
IF_pred_taken  input  1  predictor's taken estimate for IF instruction
IF_pred_target  input  XLEN  predictor's target for IF instruction
stall_IF_ID  input  1  hold IF/ID tracking register
stall_ID_EX  input  1  hold ID/EX tracking register
EX_actual_taken  input  1  branch comparator result for instruction in EX
flush  output  1  squash IF/ID and ID/EX (mispredict this cycle)
redirect_pc  output  XLEN  corrected fetch PC, valid when flush=1
EX_branch  output  1  valid branch resolving in EX (to predictor)
EX_branch_taken  output  1  actual outcome (to predictor)
branch_count  output  CNT_W  resolved branches
mispredict_count  output  CNT_W  mispredicted branches

Behaviour:
- Tracking entry fields: valid, pred_taken, pred_target, pc, imm.
- Capture: the IF/ID entry loads valid = (IF_opcode == OPCODE_BRANCH), along with the other fields, each cycle unless stall_IF_ID is high.
- Advance: the ID/EX entry loads from IF/ID unless stall_ID_EX is high. If ID/EX advances while IF/ID is stalled, ID/EX.valid loads 0 (a bubble).
- Resolution (combinational from the ID/EX entry, same cycle):
  - actual_target = pc + imm, modulo 2^XLEN.
  - fallthrough = pc + 4, modulo 2^XLEN.
- Resolution gating: resolution is enabled when ID/EX.valid = 1, state = RUN, and stall_ID_EX = 0. A stalled branch resolves exactly once, in its release cycle.
- EX_branch = resolution enabled.
- EX_branch_taken = EX_actual_taken when EX_branch = 1, else 0.
- An X on EX_actual_taken while EX_branch = 1 is a bench error.
- mispredict = EX_branch and any of:
  - pred_taken != actual_taken;
  - pred_taken and actual_taken and pred_target != actual_target.
- flush = mispredict.
- redirect_pc = actual_taken ? actual_target : fallthrough when flush = 1, else 0.
- State machine:
  - RUN -> RECOVER on mispredict.
  - RECOVER -> RUN unconditionally after 1 cycle.
  - In RECOVER no resolution occurs: EX_branch = 0 and flush = 0. This guarantees at most one flush per two cycles.
- Flush clock edge: both tracking entries clear valid. Flush overrides both stalls.
- Counters:
  - branch_count increments on each EX_branch.
  - mispredict_count increments on each mispredict.
  - Both saturate at 2^CNT_W-1 and never wrap.
- Reset (async, any time, including mid-recovery):
  - state = RUN; all entries invalid; counters 0.
  - flush = 0, redirect_pc = 0, EX_branch = 0, EX_branch_taken = 0.
- Non-branch opcodes never produce EX_branch.
- Back-to-back branches in IF/ID and ID/EX are tracked independently. If the older one mispredicts, the younger is squashed and never counted.

Decomposition:
- Shared header (existing opcode header) supplies OPCODE_BRANCH. Add a BRU state encoding constant there (RUN = 0, RECOVER = 1).
- One natural sub-module: bru_track_stage, a single tracking register with load/stall/flush/bubble control, instantiated twice.

Test Plan:
- Predicted not-taken, actual not-taken: branch at pc=0x100, imm=0x40, pred_taken=0, EX_actual_taken=0 -> EX_branch=1, EX_branch_taken=0, flush=0, branch_count=1, mispredict_count=0.
- Predicted not-taken, actual taken: pc=0x100, imm=0x40 -> flush=1, redirect_pc=0x140 in the EX cycle; next cycle RECOVER, flush=0; both tracking entries invalid; mispredict_count=1.
- Predicted taken to 0x140, actual not-taken: pc=0x100 -> flush=1, redirect_pc=0x104.
- Predicted taken with wrong target (0x180, real 0x140), actual taken -> flush=1, redirect_pc=0x140.
- Stall and squash:
  - Branch held in ID/EX with stall_ID_EX=1 for 3 cycles -> EX_branch=0 while stalled, EX_branch=1 exactly once on release.
  - Back-to-back branches, older mispredicts -> younger never reaches EX_branch.
- Reset and saturation:
  - Reset asserted during RECOVER -> all outputs 0, state RUN, counters 0.
  - CNT_W=4 with 20 resolved branches -> branch_count holds at 15.
